// File: rtl/ysyx_ifu_fetch.sv
// Instruction-fetch front end: PC, a single outstanding fetch toward the bus arbiter,
// and a small instruction queue for the IDU. Optional counters: define YSYX_IFU_PERF_EN.
module ysyx_ifu_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arvalid,
    input  logic [DATA_W-1:0] ifu_rdata,
    input  logic              ifu_rvalid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q, count;
    logic [DATA_W-1:0] inst_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
    logic              full, empty, push, pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!redirect_valid && !full) state_d = REQ;
            REQ:     if (ifu_rvalid) state_d = IDLE;
                     else if (redirect_valid) state_d = DROP;
            DROP:    if (ifu_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The issued address is latched at issue so it survives redirects while in DROP.
    always_comb begin
        ifu_arvalid = (state_q != IDLE);
        ifu_araddr  = addr_q;
        push        = (state_q == REQ) && ifu_rvalid && !redirect_valid;
        pop         = inst_ready && !empty && !redirect_valid;
        addr_d      = (state_q == IDLE && state_d == REQ) ? fetch_pc_q : addr_q;
        fetch_pc_d  = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (push)      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                inst_mem_q[wr_ptr_q[PTR_W-1:0]] <= ifu_rdata;
                pc_mem_q[wr_ptr_q[PTR_W-1:0]]   <= fetch_pc_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign inst_o       = inst_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign pc_o         = pc_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign inst_valid_o = !empty;

`ifdef YSYX_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (ifu_arvalid && !ifu_rvalid && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (state_q == DROP && ifu_rvalid && perf_drop_cnt != '1)
                perf_drop_cnt <= perf_drop_cnt + 1'b1;
        end
    end

    final $display("[IFU] fetch=%0d stall=%0d drop=%0d",
                   perf_fetch_cnt, perf_stall_cnt, perf_drop_cnt);
`else
`endif
endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Directed bench for ysyx_ifu_fetch: the bench plays the arbiter, queues the
// expected {pc,inst} per pushed fetch, and checks each entry as the IDU takes it.
module tb_ysyx_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ifu_araddr, ifu_rdata, redirect_pc, inst_o, pc_o;
    logic        ifu_arvalid, ifu_rvalid, redirect_valid, inst_valid_o, inst_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t sb[$];

    ysyx_ifu_fetch dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arvalid(input string tag);
        int n = 0;
        while (!ifu_arvalid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_arvalid"}, 64'(ifu_arvalid), 64'd1);
    endtask

    // Return the word for the address currently requested after dly idle cycles.
    task automatic respond(input int dly, input bit push);
        logic [31:0] a;
        a = ifu_araddr;
        repeat (dly) tick();
        ifu_rdata  = word_of(a);
        ifu_rvalid = 1'b1;
        if (push) sb.push_back({a, word_of(a)});
        tick();
        ifu_rvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (8) tick();
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // IDU side: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin : consumer
        ent_t e;
        if (!rst && inst_valid_o && inst_ready && !redirect_valid) begin
            if (sb.size() == 0) check("unexpected_pop", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("head_pc", 64'(pc_o), 64'(e.pc));
                check("head_inst", 64'(inst_o), 64'(e.inst));
            end
        end
    end

    initial begin
        logic [31:0] a_old;
        ifu_rdata = '0; ifu_rvalid = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b1;
        #1 rst = 1'b1;
        tick(); tick();
        check("rst_araddr", 64'(ifu_araddr), 64'(RST_PC));
        check("rst_arvalid", 64'(ifu_arvalid), 64'd0);
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        check("rst_pc", 64'(pc_o), 64'd0);
        rst = 1'b0;

        // 1: sequential fetches with ready=1
        for (int i = 0; i < 3; i++) begin
            wait_arvalid("t1");
            check("t1_araddr", 64'(ifu_araddr), 64'(RST_PC + 32'(4 * i)));
            respond(2, 1'b1);
        end
        drain("t1");

        // 2: queue fills to 4 with ready=0, then one pop frees a slot
        rst = 1'b1; tick(); rst = 1'b0; sb.delete();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_arvalid("t2");
            check("t2_araddr", 64'(ifu_araddr), 64'(RST_PC + 32'(4 * i)));
            respond(1, 1'b1);
        end
        repeat (5) tick();
        check("t2_full_arvalid", 64'(ifu_arvalid), 64'd0);
        check("t2_full_inst", 64'(inst_o), 64'(word_of(RST_PC)));
        inst_ready = 1'b1; tick(); inst_ready = 1'b0;
        wait_arvalid("t2b");
        check("t2_fifth_araddr", 64'(ifu_araddr), 64'h3000_0010);
        respond(0, 1'b1);
        inst_ready = 1'b1;
        drain("t2");

        // 3: redirect while a fetch is pending -> stale word dropped
        wait_arvalid("t3");
        a_old = ifu_araddr;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        check("t3_drop_addr", 64'(ifu_araddr), 64'(a_old));
        check("t3_drop_arvalid", 64'(ifu_arvalid), 64'd1);
        respond(2, 1'b0);
        check("t3_empty", 64'(inst_valid_o), 64'd0);
        wait_arvalid("t3b");
        check("t3_new_araddr", 64'(ifu_araddr), 64'h8000_0000);
        respond(1, 1'b1);
        drain("t3");

        // 4: redirect coincident with rvalid; queued entry flushed too
        inst_ready = 1'b0;
        wait_arvalid("t4");
        respond(0, 1'b1);
        wait_arvalid("t4b");
        ifu_rdata = 32'h1234_5678; ifu_rvalid = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        ifu_rvalid = 1'b0; redirect_valid = 1'b0;
        sb.delete();
        check("t4_flushed", 64'(inst_valid_o), 64'd0);
        inst_ready = 1'b1;
        wait_arvalid("t4c");
        check("t4_araddr", 64'(ifu_araddr), 64'h0000_1000);
        respond(1, 1'b1);
        drain("t4");

        // 5: 20-cycle stall keeps the request stable
        begin
            bit stable;
`ifdef YSYX_IFU_PERF_EN
            logic [31:0] s0;
`endif
            wait_arvalid("t5");
            a_old = ifu_araddr;
            stable = 1'b1;
`ifdef YSYX_IFU_PERF_EN
            s0 = dut.perf_stall_cnt;
`endif
            repeat (20) begin
                tick();
                if (ifu_araddr !== a_old || ifu_arvalid !== 1'b1) stable = 1'b0;
            end
            check("t5_stable", 64'(stable), 64'd1);
`ifdef YSYX_IFU_PERF_EN
            check("t5_perf_stall", 64'(dut.perf_stall_cnt - s0), 64'd20);
`endif
            respond(0, 1'b1);
            drain("t5");
        end

        // 6: reset in the middle of a request
        wait_arvalid("t6");
        rst = 1'b1;
        #1;
        check("t6_arvalid_drop", 64'(ifu_arvalid), 64'd0);
        check("t6_araddr_rst", 64'(ifu_araddr), 64'(RST_PC));
        sb.delete();
        tick();
        rst = 1'b0;
        wait_arvalid("t6b");
        check("t6_restart", 64'(ifu_araddr), 64'(RST_PC));
        respond(1, 1'b1);
        drain("t6");

        // 7: PC increment wraps past the top of the address space
        wait_arvalid("t7");
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        respond(0, 1'b0);
        wait_arvalid("t7b");
        check("t7_top", 64'(ifu_araddr), 64'hFFFF_FFFC);
        respond(1, 1'b1);
        wait_arvalid("t7c");
        check("t7_wrap", 64'(ifu_araddr), 64'h0000_0000);
        respond(1, 1'b1);
        drain("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
